// File: rtl/kbd_pkg.sv
// Shared PS/2 scan-code constants, prefix FSM states and key-code type.
package kbd_pkg;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    // {ext, code}
    typedef logic [8:0] key_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } prefix_state_t;

    // Bytes that are never part of a key sequence (acks, BAT, errors, pause prefix).
    function automatic logic is_dropped(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/kbd_held_table.sv
// Ordered table of held keys: oldest at index 0, newest at index count-1.
module kbd_held_table
    import kbd_pkg::*;
#(
    parameter int MAX_HELD = 4,
    localparam int CNT_W   = $clog2(MAX_HELD + 1),
    localparam int IDX_W   = $clog2(MAX_HELD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8:0]       lookup_code,
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic [8:0]       newest,
    input  logic             do_append,
    input  logic [8:0]       append_code,
    input  logic             do_remove,
    input  logic [IDX_W-1:0] remove_idx
);

    key_code_t entries [MAX_HELD];

    // Parallel match against occupied entries; keys are unique so at most one hits.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < MAX_HELD; i++) begin
            if (CNT_W'(i) < count && entries[i] == lookup_code) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Newest entry, or zero when the table is empty.
    always_comb begin
        newest = '0;
        for (int unsigned i = 0; i < MAX_HELD; i++) begin
            if (CNT_W'(i + 1) == count) newest = entries[i];
        end
    end

    assign full = (count == CNT_W'(MAX_HELD));

    // Append at the tail, or remove an entry and slide younger entries down one.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            for (int unsigned i = 0; i < MAX_HELD; i++) entries[i] <= '0;
        end else if (do_append) begin
            for (int unsigned i = 0; i < MAX_HELD; i++) begin
                if (CNT_W'(i) == count) entries[i] <= append_code;
            end
            count <= count + CNT_W'(1);
        end else if (do_remove) begin
            for (int unsigned i = 0; i + 1 < MAX_HELD; i++) begin
                if (IDX_W'(i) >= remove_idx) entries[i] <= entries[i + 1];
            end
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/kbd_rollover_tracker.sv
// PS/2 make/break decoder with multi-key rollover tracking.
module kbd_rollover_tracker
    import kbd_pkg::*;
#(
    parameter int MAX_HELD = 4,
    parameter int COUNT_W  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           byte_valid,
    input  logic [7:0]                     byte_data,
    output logic [8:0]                     cur_code,
    output logic                           is_press,
    output logic [$clog2(MAX_HELD+1)-1:0]  held_cnt,
    output logic [COUNT_W-1:0]             press_count,
    output logic                           evt_valid,
    output logic                           evt_make,
    output logic [8:0]                     evt_code,
    output logic                           overflow
);

    localparam int CNT_W = $clog2(MAX_HELD + 1);
    localparam int IDX_W = $clog2(MAX_HELD);

    prefix_state_t state, state_next;
    logic          dec_valid;
    logic          dec_make;
    key_code_t     dec_code;

    logic             tbl_hit;
    logic [IDX_W-1:0] tbl_hit_idx;
    logic             tbl_full;
    logic [CNT_W-1:0] tbl_count;
    logic [8:0]       tbl_newest;
    logic             do_append;
    logic             do_remove;

    // Prefix state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Prefix decode: a repeated 0xE0 while extended keeps the extended prefix.
    always_comb begin
        state_next = state;
        dec_valid  = 1'b0;
        dec_make   = 1'b0;
        dec_code   = '0;
        if (byte_valid) begin
            if (is_dropped(byte_data)) begin
                state_next = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (byte_data == PFX_EXT)      state_next = ST_EXT;
                        else if (byte_data == PFX_BRK) state_next = ST_BRK;
                        else begin
                            dec_valid = 1'b1;
                            dec_make  = 1'b1;
                            dec_code  = {1'b0, byte_data};
                        end
                    end
                    ST_EXT: begin
                        if (byte_data == PFX_BRK)      state_next = ST_EXT_BRK;
                        else if (byte_data == PFX_EXT) state_next = ST_EXT;
                        else begin
                            dec_valid  = 1'b1;
                            dec_make   = 1'b1;
                            dec_code   = {1'b1, byte_data};
                            state_next = ST_IDLE;
                        end
                    end
                    ST_BRK, ST_EXT_BRK: begin
                        state_next = ST_IDLE;
                        if (byte_data != PFX_EXT && byte_data != PFX_BRK) begin
                            dec_valid = 1'b1;
                            dec_code  = {state == ST_EXT_BRK, byte_data};
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end
    end

    assign do_append = dec_valid &&  dec_make && !tbl_hit && !tbl_full;
    assign do_remove = dec_valid && !dec_make &&  tbl_hit;

    kbd_held_table #(
        .MAX_HELD (MAX_HELD)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .lookup_code (dec_code),
        .hit         (tbl_hit),
        .hit_idx     (tbl_hit_idx),
        .full        (tbl_full),
        .count       (tbl_count),
        .newest      (tbl_newest),
        .do_append   (do_append),
        .append_code (dec_code),
        .do_remove   (do_remove),
        .remove_idx  (tbl_hit_idx)
    );

    // Event pulse, press counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid   <= 1'b0;
            evt_make    <= 1'b0;
            evt_code    <= '0;
            press_count <= '0;
            overflow    <= 1'b0;
        end else begin
            evt_valid <= dec_valid;
            if (dec_valid) begin
                evt_make <= dec_make;
                evt_code <= dec_code;
            end
            if (do_append) press_count <= press_count + COUNT_W'(1);
            if (dec_valid && dec_make && !tbl_hit && tbl_full)
                overflow <= 1'b1;
            else if (do_remove && tbl_count == CNT_W'(1))
                overflow <= 1'b0;
        end
    end

    assign cur_code = tbl_newest;
    assign is_press = (tbl_count != '0);
    assign held_cnt = tbl_count;

endmodule

// File: doc/kbd_rollover_tracker.md
# kbd_rollover_tracker

Multi-key successor to the single-key PS/2 keyboard display path: consumes the byte stream from the PS/2 receiver, decodes make/break/extended scan-code sequences, and tracks up to `MAX_HELD` simultaneously held keys in an ordered table. It exposes the newest still-held key, a held-key count, a typematic-filtered press counter and a per-event pulse. The hex-display and ASCII-lookup stages consume it downstream.

## Interface
- `MAX_HELD`, 4: held-key table depth (≥2).
- `COUNT_W`, 8: press counter width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `byte_valid` in 1: one-cycle pulse, a received scan byte is on `byte_data`.
- `byte_data` in 8: scan byte.
- `cur_code` out 9: `{ext, code}` of newest held key; 0 when none held.
- `is_press` out 1: at least one key held.
- `held_cnt` out $clog2(MAX_HELD+1): entries in table.
- `press_count` out COUNT_W: accepted new presses, wraps modulo 2^COUNT_W.
- `evt_valid` out 1: one-cycle pulse per decoded make/break.
- `evt_make` out 1: 1 = make, 0 = break; valid with `evt_valid`.
- `evt_code` out 9: `{ext, code}` of event; valid with `evt_valid`.
- `overflow` out 1: sticky; a make was dropped because table full.

## Operation
- Prefix FSM states: IDLE, EXT (after 0xE0), BRK (after 0xF0), EXT_BRK (0xE0 then 0xF0).
  - IDLE: 0xE0→EXT, 0xF0→BRK, code→make(ext=0).
  - EXT: 0xF0→EXT_BRK, code→make(ext=1), back to IDLE.
  - BRK: code→break(ext=0), IDLE. EXT_BRK: code→break(ext=1), IDLE.
  - 0xE0 in BRK/EXT_BRK or 0xF0 in BRK/EXT_BRK: protocol error, return to IDLE, byte dropped, no event.
- Dropped bytes in any state (no event, FSM → IDLE): 0x00, 0xAA, 0xE1, 0xEE, 0xFA, 0xFE, 0xFF.
- Make of key already in table (typematic repeat): `evt_valid` pulses with `evt_make`=1; table, order and `press_count` unchanged.
- Make of new key, table not full: append at index `held_cnt`; `press_count`+1; becomes `cur_code`.
- Make of new key, table full: `evt_valid` still pulses; no append, no count; `overflow` set.
- Break of held key: remove entry, shift younger entries down one (order preserved); `cur_code` = new newest or 0.
- Break of unheld key: `evt_valid` pulses, `evt_make`=0; no state change.
- `overflow` clears only when `held_cnt` reaches 0 via a break, or on `rst`.
- Reset values: FSM IDLE, table empty, `cur_code`=0, `is_press`=0, `held_cnt`=0, `press_count`=0, `evt_valid`=0, `evt_make`=0, `evt_code`=0, `overflow`=0.

## Timing
- Event outputs and table/counter updates registered: visible the cycle after the `byte_valid` carrying the final code byte (latency 1).
- `is_press`, `cur_code`, `held_cnt` derive from registered table; consistent in the same cycle as `evt_valid`.
- Back-to-back `byte_valid` on consecutive cycles supported; each byte processed fully, no stall, no backpressure.
- `rst` asserted mid-sequence (e.g. after 0xE0) abandons it; first byte after reset decodes from IDLE.
- `rst` wins over a coincident `byte_valid`.

## Structure
- Shared package `kbd_pkg`: prefix constants (0xE0, 0xF0), dropped-byte list, FSM state enum, 9-bit key-code typedef.
- One sub-module `kbd_held_table`: ordered MAX_HELD-entry table with parallel match, append, remove-and-compact; ports for lookup hit, full, count, newest entry. Prefix FSM and counters stay in top.

## Test plan
- Reset, then bytes 0x1C, 0xF0, 0x1C -> make evt 0x01C, `press_count`=1, `cur_code`=0x01C, `is_press`=1; then break evt, `held_cnt`=0, `cur_code`=0.
- 0xE0,0x75 then 0xE0,0xF0,0x75 -> make evt 0x175, break evt 0x175; `press_count`+1 once.
- 0x1C ×5 (typematic) -> 5 make pulses, `press_count`=1, `held_cnt`=1.
- MAX_HELD=4: makes 0x1C,0x32,0x21,0x23,0x24 -> fifth sets `overflow`, `held_cnt`=4, `press_count`=4; break 0x32 -> order {0x1C,0x21,0x23}, `cur_code`=0x023; release all -> `overflow`=0.
- 0xFA, 0xAA, 0xE0 then 0xFA, then 0x1C -> no events for dropped bytes; 0x1C decodes as non-extended make 0x01C.
- Send 0xE0, assert `rst` one cycle, send 0x75 -> make evt 0x075 (ext=0), all counters restarted from reset values.
